// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memory window, FSM states
// and the port-index type.
package dmem_pkg;

    localparam logic [31:0] DMEM_BASE = 32'h7FF0_0000;
    localparam logic [31:0] DMEM_TOP  = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    // Unsigned inclusive range test against the data-memory window.
    function automatic logic addr_in_window(input logic [31:0] addr);
        return (addr >= DMEM_BASE) && (addr <= DMEM_TOP);
    endfunction

endpackage

// File: rtl/dmem_window_check.sv
// Combinational address-window check: high when the word address falls
// inside the data-memory window.
module dmem_window_check
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_in_window
);

    logic [31:0] w_addr32;

    // Normalise the address to the 32-bit window compare width.
    always_comb begin
        w_addr32    = 32'(i_addr);
        o_in_window = addr_in_window(w_addr32);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of the
// single-port data memory. One access takes IDLE -> ACCESS -> RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              stall0,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            r_state;
    state_e            w_next;
    port_idx_t         r_grant;
    port_idx_t         r_last_grant;
    port_idx_t         w_win;
    logic              w_take;
    logic              w_capture;
    logic              w_finish;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_in_win;
    logic              r_in_win;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    // Round-robin pick: on a tie the port not served last wins.
    always_comb begin
        w_win = PORT0;
        if (req0 && req1) begin
            w_win = ~r_last_grant;
        end else if (req1) begin
            w_win = PORT1;
        end else begin
            w_win = PORT0;
        end
    end

    // Steer the winning port's request fields toward the request latch.
    always_comb begin
        w_sel_we    = we0;
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
        if (w_win == PORT1) begin
            w_sel_we    = we1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end else begin
            w_sel_we    = we0;
            w_sel_addr  = addr0;
            w_sel_wdata = wdata0;
        end
    end

    dmem_window_check #(
        .ADDR_W (ADDR_W)
    ) u_window (
        .i_addr      (w_sel_addr),
        .o_in_window (w_in_win)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and per-state control strobes.
    always_comb begin
        w_next    = r_state;
        w_take    = 1'b0;
        w_capture = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_next = ACCESS;
                    w_take = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            ACCESS: begin
                w_next    = RESP;
                w_capture = 1'b1;
            end
            RESP: begin
                w_next   = IDLE;
                w_finish = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request latch, memory drive (non-zero only during ACCESS), response
    // register, completion pulses and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant      <= PORT0;
            r_last_grant <= PORT1;
            r_in_win     <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_take) begin
                r_grant     <= w_win;
                r_in_win    <= w_in_win;
                r_mem_write <= w_sel_we & w_in_win;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end else begin
                r_mem_write <= 1'b0;
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
            end
            r_ack0 <= w_capture & (r_grant == PORT0);
            r_ack1 <= w_capture & (r_grant == PORT1);
            if (w_capture) begin
                r_rdata <= r_in_win ? mem_rdata : '0;
                r_err   <= ~r_in_win;
            end else begin
                r_rdata <= r_rdata;
                r_err   <= r_err;
            end
            if (w_finish) begin
                r_last_grant <= r_grant;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall0    = req0 & ~r_ack0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err, stall0, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [16];
    logic        mem_init;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int a0_cnt = 0;
    int a1_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .err       (err),
        .stall0    (stall0),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: 16 words indexed by the low address bits.
    assign mem_rdata = mem[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_A5A5;
        end else if (mem_write) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    // Event counters sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_write === 1'b1) wr_cnt <= wr_cnt + 1;
        if (ack0 === 1'b1) a0_cnt <= a0_cnt + 1;
        if (ack1 === 1'b1) a1_cnt <= a1_cnt + 1;
        if (ack0 === 1'b1 && ack1 === 1'b1) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 1'b0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Both ports request together; each drops its request on its own ack.
    task automatic run_tie(input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                           output int c0, output int c1, output logic [31:0] rd1);
        c0 = -1; c1 = -1; rd1 = 32'h0;
        drive(1'b0, 1'b1, w0, a0, d0);
        drive(1'b1, 1'b1, w1, a1, d1);
        for (int c = 1; c <= 12 && (c0 < 0 || c1 < 0); c++) begin
            step();
            if (ack0 === 1'b1 && c0 < 0) begin
                c0 = c;
                drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (ack1 === 1'b1 && c1 < 0) begin
                c1 = c;
                rd1 = rdata;
                drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          got, w_start, a0_start, a1_start, c0, c1;
        logic [31:0] rd, rd1;
        logic        er;

        vecs[0] = '{1'b0, 1'b1, 32'h7FFF_FFFE, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1};
        vecs[1] = '{1'b0, 1'b0, 32'h7FFF_FFFE, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_DEAD, 1'b0, 32'h0,        1'b1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,        1'b1, 32'h0,         1'b1, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h7FF0_0000, 32'h0,        1'b1, 32'hA5A5_A5A5, 1'b0, 0};
        vecs[5] = '{1'b0, 1'b0, 32'h7FEF_FFFF, 32'h0,        1'b1, 32'h0,         1'b1, 0};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b1, 32'h0,         1'b1, 0};

        reset = 1'b1; mem_init = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); step();
        check("reset_ctl", {60'h0, ack0, ack1, err, mem_write}, 64'h0);
        check("reset_rdata", {32'h0, rdata}, 64'h0);
        check("reset_maddr", {mem_addr, mem_wdata}, 64'h0);
        mem_init = 1'b0; reset = 1'b0;
        step();

        // Single-port transactions from the table.
        for (int v = 0; v < 7; v++) begin
            w_start = wr_cnt; a0_start = a0_cnt; a1_start = a1_cnt;
            got = -1; rd = 32'h0; er = 1'b0;
            drive(vecs[v].port, 1'b1, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            for (int c = 1; c <= 8 && got < 0; c++) begin
                step();
                if ((vecs[v].port == 1'b0 ? ack0 : ack1) === 1'b1) begin
                    got = c; rd = rdata; er = err;
                    drive(vecs[v].port, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
            drive(vecs[v].port, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
            check($sformatf("vec%0d_latency", v), 64'(got), 64'd2);
            check($sformatf("vec%0d_err", v), {63'h0, er}, {63'h0, vecs[v].exp_err});
            if (vecs[v].chk_rd) check($sformatf("vec%0d_rdata", v), {32'h0, rd}, {32'h0, vecs[v].exp_rdata});
            check($sformatf("vec%0d_writes", v), 64'(wr_cnt - w_start), 64'(vecs[v].exp_wr));
            check($sformatf("vec%0d_acks", v), {32'(a0_cnt - a0_start), 32'(a1_cnt - a1_start)},
                  vecs[v].port ? {32'd0, 32'd1} : {32'd1, 32'd0});
        end
        check("oob_mem_untouched", {32'h0, mem[0]}, {32'h0, 32'hA5A5_A5A5});

        // Tie straight after reset: port 0 first, then port 1 reads the new data.
        reset = 1'b1; step(); reset = 1'b0; step();
        run_tie(1'b1, 32'h7FFF_FFFF, 32'h1234_5678, 1'b0, 32'h7FFF_FFFF, 32'h0, c0, c1, rd1);
        check("tie1_ack0_cycle", 64'(c0), 64'd2);
        check("tie1_ack1_cycle", 64'(c1), 64'd5);
        check("tie1_rdata", {32'h0, rd1}, {32'h0, 32'h1234_5678});
        run_tie(1'b0, 32'h7FFF_FFFE, 32'h0, 1'b0, 32'h7FFF_FFFE, 32'h0, c0, c1, rd1);
        check("tie3_ack0_cycle", 64'(c0), 64'd2);
        check("tie3_ack1_cycle", 64'(c1), 64'd5);

        // Port 0 holds req0 for three back-to-back reads.
        drive(1'b0, 1'b1, 1'b0, 32'h7FFF_FFFE, 32'h0);
        #1;
        check("hold_stall_initial", {63'h0, stall0}, 64'd1);
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("hold_ack0_c%0d", c), {63'h0, ack0}, {63'h0, (c % 3) == 2});
            check($sformatf("hold_stall0_c%0d", c), {63'h0, stall0}, {63'h0, (c % 3) != 2});
            if ((c % 3) == 2) check($sformatf("hold_rdata_c%0d", c), {32'h0, rdata}, {32'h0, 32'hDEAD_BEEF});
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Reset during ACCESS of a port 1 read: no ack, everything cleared.
        drive(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFE, 32'h0);
        step();
        check("rst_mid_addr", {32'h0, mem_addr}, {32'h0, 32'h7FFF_FFFE});
        a1_start = a1_cnt;
        reset = 1'b1;
        #1;
        check("rst_mid_ctl", {59'h0, ack0, ack1, err, mem_write, stall0}, 64'h0);
        check("rst_mid_data", {rdata, mem_addr}, 64'h0);
        check("rst_mid_wdata", {32'h0, mem_wdata}, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        reset = 1'b0;
        step(); step(); step(); step();
        check("rst_mid_no_ack1", 64'(a1_cnt - a1_start), 64'd0);
        run_tie(1'b0, 32'h7FFF_FFFE, 32'h0, 1'b0, 32'h7FFF_FFFE, 32'h0, c0, c1, rd1);
        check("rst_last_grant_tie", 64'(c0), 64'd2);

        // req1 pulsed for one cycle while port 0 is in service.
        w_start = wr_cnt; a1_start = a1_cnt;
        drive(1'b0, 1'b1, 1'b0, 32'h7FFF_FFFE, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h7FFF_FFFE, 32'h0BAD_0BAD);
        step();
        check("pulse_ack0", {63'h0, ack0}, 64'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); step(); step(); step();
        check("pulse_no_ack1", 64'(a1_cnt - a1_start), 64'd0);
        check("pulse_no_write", 64'(wr_cnt - w_start), 64'd0);
        check("pulse_mem_kept", {32'h0, mem[14]}, {32'h0, 32'hDEAD_BEEF});
        check("acks_exclusive", 64'(both_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
